// File: rtl/corevx_muldiv_if.sv
// corevx_muldiv request/response bundle between execute and the M unit.
// master = execute side, slave = multiply/divide unit.
interface corevx_muldiv_if #(
  parameter int WIDTH = 32
) ();
  logic             req_valid;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_rs1;
  logic [WIDTH-1:0] req_rs2;
  logic             req_ready;
  logic             kill;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_result;
  logic             busy;

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, kill,
    input  req_ready, rsp_valid, rsp_result, busy
  );

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, kill,
    output req_ready, rsp_valid, rsp_result, busy
  );
endinterface

// File: rtl/corevx_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide.
// Ports: clk, rst_n (async low), io (slave: req_*, kill, rsp_*, busy).
module corevx_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  corevx_muldiv_if.slave   io
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [2:0]         f3;
  logic               neg;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;

  logic               accept, last;
  logic [2:0]         f;
  logic               sg1, sg2, n1, n2, neg_in;
  logic [WIDTH-1:0]   mag1, mag2;
  logic               zero2, ovf, fast;
  logic [WIDTH-1:0]   fast_res;
  logic [WIDTH:0]     sum, sh, diff;
  logic [2*WIDTH-1:0] mul_fix;
  logic [WIDTH-1:0]   res;

  assign f      = io.req_funct3;
  assign accept = io.req_valid && io.req_ready;
  assign last   = cnt == CW'(WIDTH - 1);

  assign sg1  = (f == 3'd1) | (f == 3'd2) | (f == 3'd4) | (f == 3'd6);
  assign sg2  = (f == 3'd1) | (f == 3'd4) | (f == 3'd6);
  assign n1   = sg1 & io.req_rs1[WIDTH-1];
  assign n2   = sg2 & io.req_rs2[WIDTH-1];
  assign mag1 = n1 ? -io.req_rs1 : io.req_rs1;
  assign mag2 = n2 ? -io.req_rs2 : io.req_rs2;
  // REM follows the dividend sign; MUL*/DIV follow the sign product
  assign neg_in = (f[2] & f[1]) ? n1 : (n1 ^ n2);

  assign zero2 = io.req_rs2 == '0;
  assign ovf   = (f == 3'd4 || f == 3'd6) &&
                 io.req_rs1 == {1'b1, {(WIDTH-1){1'b0}}} &&
                 io.req_rs2 == '1;
  assign fast  = f[2] && (zero2 || ovf);

  always_comb begin
    fast_res = '0;
    if (zero2)
      fast_res = f[1] ? io.req_rs1 : '1;
    else if (!f[1])
      fast_res = io.req_rs1;
  end

  // Multiply: acc = {partial, multiplier}, shifted right each step.
  // Divide:   acc = {remainder, dividend/quotient}, shifted left.
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
           (acc[0] ? {1'b0, opb} : '0);
    sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = sh - {1'b0, opb};
    if (f3[2])
      acc_nxt = {diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0],
                 acc[WIDTH-2:0], ~diff[WIDTH]};
    else
      acc_nxt = {sum, acc[WIDTH-1:1]};
  end

  always_comb begin
    mul_fix = neg ? -acc_nxt : acc_nxt;
    res     = '0;
    unique case (1'b1)
      f3 == 3'd0:
        res = mul_fix[WIDTH-1:0];
      !f3[2] && f3 != 3'd0:
        res = mul_fix[2*WIDTH-1:WIDTH];
      f3[2] && !f3[1]:
        res = neg ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
      f3[2] && f3[1]:
        res = neg ? -acc_nxt[2*WIDTH-1:WIDTH]
                  : acc_nxt[2*WIDTH-1:WIDTH];
      default: res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = fast ? DONE : CALC;
      CALC: begin
        if (io.kill)   state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      f3       <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      result_q <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= state_nxt != IDLE;
      if (accept) begin
        f3  <= f;
        neg <= neg_in;
        cnt <= '0;
        opb <= f[2] ? mag2 : mag1;
        acc <= {{WIDTH{1'b0}}, f[2] ? mag1 : mag2};
        if (fast) result_q <= fast_res;
      end else if (state == CALC) begin
        acc <= acc_nxt;
        cnt <= cnt + CW'(1);
        if (last && !io.kill) result_q <= res;
      end
    end
  end

  assign io.req_ready  = (state == IDLE) && !io.kill;
  assign io.rsp_valid  = state == DONE;
  assign io.rsp_result = result_q;
  assign io.busy       = busy_q;
endmodule
